pcm_sample_feeder: RTL and testbench
====================================

# pcm_sample_feeder

Sample-rate buffer that sits directly upstream of the 1-bit delta-sigma DAC. It accepts signed PCM samples from the processor/bus side through a valid/ready handshake and stores them in a small FIFO. At a programmable sample rate it pops one sample and holds it on `pcm_out`, which drives the DAC's `pcm_in` port. On FIFO underrun it outputs mute (0) and records a sticky flag.

## Interface
- `W`, 16, sample width; two's-complement signed, matches the DAC input width.
- `ADDR_W`, 4, FIFO address width; depth = 2^ADDR_W.
- `DIV_W`, 16, width of the sample-period divisor.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_data`  in  W  sample to enqueue.
- `wr_valid`  in  1  `wr_data` is valid.
- `wr_ready`  out  1  FIFO can accept a sample; equals !full.
- `div`  in  DIV_W  sample period minus 1, in clk cycles.
- `en`  in  1  playback enable.
- `clr_underrun`  in  1  one-cycle pulse that clears `underrun`.
- `pcm_out`  out  W  held sample to the DAC.
- `sample_tick`  out  1  one-cycle pulse, high in the first cycle a new `pcm_out` value is presented.
- `underrun`  out  1  sticky flag: a tick occurred while the FIFO was empty.
- `level`  out  ADDR_W+1  current FIFO occupancy, 0..2^ADDR_W.
- `empty`  out  1  level == 0.
- `full`  out  1  level == 2^ADDR_W.

## Operation
- Push: occurs when `wr_valid && wr_ready`. `wr_ready` is derived from the current `full` only. A pop in the same cycle does not make room for a push while full.
- Rate counter `cnt` (DIV_W bits):
  - When `en`=0: `cnt` is held at 0; no ticks; `pcm_out` holds its value.
  - When `en`=1: `tick_c = (cnt >= div)`. On `tick_c`, `cnt` becomes 0; otherwise `cnt` increments.
  - The `>=` compare ensures that lowering `div` mid-count fires a tick on the next cycle and never wraps.
  - `div`=0 produces a tick every cycle.
- On `tick_c`, one of two cases applies:
  - FIFO not empty: pop the head; `pcm_out` takes the head value.
  - FIFO empty: `pcm_out` becomes 0 (mute) and `underrun` is set.
- `underrun`: set has priority over `clr_underrun` in the same cycle. Otherwise `clr_underrun` clears it.
- Push and tick in the same cycle:
  - Not full and not empty: both happen; `level` is unchanged.
  - Empty: underrun/mute applies and the pushed sample is stored. There is no fall-through.
- Pointers are ADDR_W bits and wrap modulo depth. `level` is a separate ADDR_W+1-bit counter.
- Reset values: FIFO empty, `level`=0, `cnt`=0, `pcm_out`=0, `sample_tick`=0, `underrun`=0, `empty`=1, `full`=0, `wr_ready`=1.
- Reset asserted mid-operation discards all buffered samples immediately.

## Timing
- A sample pushed at edge k is poppable by a tick evaluated in the cycle after edge k.
- `pcm_out` and `sample_tick` are registered. Both update at the edge where `tick_c` was true, so `sample_tick` is high in the same cycle the new `pcm_out` appears.
- Tick period is exactly `div`+1 cycles while `en`=1 and `div` is constant.
- After `en` rises, the first tick is evaluated `div` cycles later (cnt 0→`div`), and `pcm_out` updates at the following edge.
- `level`, `empty`, `full` and `wr_ready` reflect the registered state and update one edge after the push/pop.
- FIFO memory: write is synchronous; read of the head is combinational from the registered read pointer.

## Structure
- Shared package `audio_pkg` holds:
  - default `W`, `ADDR_W` and `DIV_W` constants;
  - `MUTE_SAMPLE` = '0;
  - typedef `pcm_t` (logic signed [W-1:0]).
- One sub-module, `pcm_fifo`:
  - ports: `clk`, `reset`, `wr`, `rd`, `w_data`, `r_data`, `empty`, `full`, `level`;
  - contains the pointers, level counter and memory.
- The top level contains the rate counter, tick/pop control, output register and underrun flag.

## Test plan
- Reset, then observe with no stimulus → `pcm_out`=0, `level`=0, `empty`=1, `wr_ready`=1, `underrun`=0, and no `sample_tick` while `en`=0.
- Push 16'h1234, 16'h8000, 16'h7FFF with `div`=3, `en`=1 → ticks every 4 cycles and `pcm_out` sequence 1234, 8000, 7FFF. The fourth tick gives `pcm_out`=0 and `underrun`=1.
- Push 16 samples with `en`=0 → `full`=1, `wr_ready`=0, `level`=16. A 17th `wr_valid` is not accepted and `level` stays 16.
- `div`=0 with 4 samples queued → 4 consecutive cycles with `sample_tick`=1 and the samples in order, then mute and underrun.
- `underrun`=1 with `clr_underrun` pulsed in the same cycle as an empty tick → `underrun` stays 1. Pulsing again with no tick → `underrun`=0.
- `div` changed from 100 to 5 while `cnt`=50 → tick on the next cycle, then period 6. Asserting `reset` mid-stream → FIFO empty and `pcm_out`=0 immediately.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared PCM audio widths, sample type and mute value.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int DEF_W      = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DIV_W  = 16;

    typedef logic signed [DEF_W-1:0] pcm_t;

    localparam pcm_t MUTE_SAMPLE = '0;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/pcm_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_fifo
//  Description : Power-of-two sample FIFO with occupancy counter and
//                combinational head read.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_fifo
    import audio_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [W-1:0]      w_data,
    output logic [W-1:0]      r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    localparam int              c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_LVL = (ADDR_W+1)'(c_DEPTH);

    logic [W-1:0]      r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_DEPTH_LVL);

    // Guard locally as well so the FIFO can never over/underflow on its own.
    assign w_push  = wr && !w_full;
    assign w_pop   = rd && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign r_data = r_mem[r_rptr];
    assign empty  = w_empty;
    assign full   = w_full;
    assign level  = r_level;

endmodule : pcm_fifo
`default_nettype wire

// File: rtl/pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_sample_feeder
//  Description : Buffers PCM samples and presents one per programmable
//                sample period to the delta-sigma DAC; mutes on underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_sample_feeder
    import audio_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DIV_W-1:0]  div,
    input  logic              en,
    input  logic              clr_underrun,
    output logic [W-1:0]      pcm_out,
    output logic              sample_tick,
    output logic              underrun,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full
);

    localparam logic [W-1:0] c_MUTE = W'(MUTE_SAMPLE);

    logic [DIV_W-1:0] r_cnt;
    logic [W-1:0]     r_pcm;
    logic             r_tick;
    logic             r_underrun;

    logic             w_tick;
    logic             w_push;
    logic             w_pop;
    logic [W-1:0]     w_head;
    logic             w_empty;
    logic             w_full;

    // The >= compare makes a mid-count lowering of div fire immediately.
    assign w_tick = en && (r_cnt >= div);
    assign w_push = wr_valid && !w_full;
    assign w_pop  = w_tick && !w_empty;

    pcm_fifo #(
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (w_push),
        .rd     (w_pop),
        .w_data (wr_data),
        .r_data (w_head),
        .empty  (w_empty),
        .full   (w_full),
        .level  (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_pcm      <= c_MUTE;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tick <= w_tick;

            if (!en || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            if (w_tick) begin
                r_pcm <= w_empty ? c_MUTE : w_head;
            end

            // A new underrun wins over a clear arriving in the same cycle.
            if (w_tick && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign wr_ready    = !w_full;
    assign empty       = w_empty;
    assign full        = w_full;
    assign pcm_out     = r_pcm;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;

endmodule : pcm_sample_feeder
`default_nettype wire

// File: tb/tb_pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_sample_feeder
//  Description : Directed self-checking bench for pcm_sample_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_sample_feeder;

    localparam int W      = 16;
    localparam int ADDR_W = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [W-1:0]      wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DIV_W-1:0]  div = '0;
    logic              en = 1'b0;
    logic              clr_underrun = 1'b0;
    logic [W-1:0]      pcm_out;
    logic              sample_tick;
    logic              underrun;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcm_sample_feeder #(
        .W      (W),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .div          (div),
        .en           (en),
        .clr_underrun (clr_underrun),
        .pcm_out      (pcm_out),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .level        (level),
        .empty        (empty),
        .full         (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    // Advances until sample_tick is seen (bounded); returns edges consumed.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < limit);
        check("tick_seen", 32'(sample_tick), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int tick_cnt;
        logic [W-1:0] s4 [4];
        s4[0] = 16'h0A01; s4[1] = 16'hF002; s4[2] = 16'h5A53; s4[3] = 16'h8004;

        // ---------------- reset state ----------------
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_pcm",      32'(pcm_out),  32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        tick_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sample_tick) tick_cnt++;
        end
        check("idle_no_ticks", 32'(tick_cnt), 32'd0);

        // ---------------- div=3 playback with underrun ----------------
        div = 16'd3;
        push(16'h1234);
        push(16'h8000);
        push(16'h7FFF);
        check("p3_level", 32'(level), 32'd3);
        en = 1'b1;
        wait_tick(50, n);
        check("t1_delay", 32'(n),       32'd4);
        check("t1_pcm",   32'(pcm_out), 32'h1234);
        check("t1_level", 32'(level),   32'd2);
        wait_tick(50, n);
        check("t2_period", 32'(n),       32'd4);
        check("t2_pcm",    32'(pcm_out), 32'h8000);
        wait_tick(50, n);
        check("t3_period", 32'(n),       32'd4);
        check("t3_pcm",    32'(pcm_out), 32'h7FFF);
        check("t3_uflow",  32'(underrun), 32'd0);
        wait_tick(50, n);
        check("t4_period", 32'(n),        32'd4);
        check("t4_mute",   32'(pcm_out),  32'd0);
        check("t4_uflow",  32'(underrun), 32'd1);
        en = 1'b0;
        repeat (3) step();
        check("uflow_sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("uflow_clr", 32'(underrun), 32'd0);

        // ---------------- fill to full ----------------
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        check("full_flag",  32'(full),     32'd1);
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(level),    32'd16);
        push(16'hDEAD);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_full",  32'(full),  32'd1);

        // asynchronous reset clears immediately, before the next edge
        reset = 1'b1;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        step();
        reset = 1'b0;
        step();

        // ---------------- div=0 back-to-back ticks ----------------
        for (int i = 0; i < 4; i++) push(s4[i]);
        div = 16'd0;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("d0_tick", 32'(sample_tick), 32'd1);
            check("d0_pcm",  32'(pcm_out),     32'(s4[i]));
        end
        check("d0_uflow_pre", 32'(underrun), 32'd0);
        step();
        check("d0_mute_tick", 32'(sample_tick), 32'd1);
        check("d0_mute",      32'(pcm_out),     32'd0);
        check("d0_uflow",     32'(underrun),    32'd1);

        // clear collides with an empty tick: set wins
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("clr_vs_set", 32'(underrun), 32'd1);
        en = 1'b0;
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("clr_no_tick", 32'(underrun), 32'd0);

        // ---------------- div lowered mid-count, then reset mid-stream ----------------
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        div = 16'd100;
        en  = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sample_tick) tick_cnt++;
        end
        check("d100_no_tick", 32'(tick_cnt), 32'd0);
        div = 16'd5;
        step();
        check("dlow_tick", 32'(sample_tick), 32'd1);
        check("dlow_pcm",  32'(pcm_out),     32'h1111);
        wait_tick(50, n);
        check("d5_period", 32'(n),       32'd6);
        check("d5_pcm",    32'(pcm_out), 32'h2222);
        check("d5_level",  32'(level),   32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_pcm",   32'(pcm_out),     32'd0);
        check("mid_rst_empty", 32'(empty),       32'd1);
        check("mid_rst_level", 32'(level),       32'd0);
        check("mid_rst_tick",  32'(sample_tick), 32'd0);
        en = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("post_rst_ready", 32'(wr_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pcm_sample_feeder
`default_nettype wire
